// File: rtl/core_pkg.sv
// Shared core definitions: default datapath width, operand-select encodings
// and the forwarding-source decode used by the operand multiplexer.
package core_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        OPSEL_RS   = 2'd0,
        OPSEL_IMM  = 2'd1,
        OPSEL_PC   = 2'd2,
        OPSEL_ZERO = 2'd3
    } opsel_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2
    } fwd_src_e;

    // EX is the youngest result, so it wins over MEM.
    function automatic fwd_src_e fwd_pick(input logic ex_en, input logic mem_en);
        if (ex_en) begin
            return FWD_EX;
        end
        if (mem_en) begin
            return FWD_MEM;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/alu_operand_fwd_mux_if.sv
// Operand-mux bus: source/forward inputs, valid/ready on both sides, status.
// master = decode/ALU side, slave = the operand multiplexer.
interface alu_operand_fwd_mux_if #(
    parameter int unsigned DATA_WIDTH = core_pkg::XLEN,
    parameter int unsigned N_IN       = 4,
    parameter int unsigned SEL_WIDTH  = 2,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic [N_IN*DATA_WIDTH-1:0] in_bus;
    logic [SEL_WIDTH-1:0]       sel;
    logic                       in_valid;
    logic                       in_ready;
    logic                       fwd_ex_en;
    logic [DATA_WIDTH-1:0]      fwd_ex_data;
    logic                       fwd_mem_en;
    logic [DATA_WIDTH-1:0]      fwd_mem_data;
    logic                       flush;
    logic [DATA_WIDTH-1:0]      mux_out;
    logic                       out_valid;
    logic                       out_ready;
    logic                       sel_err;
    logic [CNT_WIDTH-1:0]       stall_cnt;

    modport master (
        output in_bus, sel, in_valid, fwd_ex_en, fwd_ex_data,
               fwd_mem_en, fwd_mem_data, flush, out_ready,
        input  in_ready, mux_out, out_valid, sel_err, stall_cnt
    );

    modport slave (
        input  in_bus, sel, in_valid, fwd_ex_en, fwd_ex_data,
               fwd_mem_en, fwd_mem_data, flush, out_ready,
        output in_ready, mux_out, out_valid, sel_err, stall_cnt
    );

endinterface

// File: rtl/skid_buf2.sv
// Generic two-entry valid/ready skid stage with flush; in_ready is a register
// so there is no combinational path from out_ready back upstream.
module skid_buf2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             drain_c;
    logic             accept_c;

    assign drain_c  = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;

    // in_ready always mirrors !skid_valid; flush leaves out_data untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (drain_c) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
                in_ready   <= 1'b1;
            end else if (accept_c) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept_c) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_operand_fwd_mux.sv
// ALU operand multiplexer: source select with EX/MEM forwarding overrides,
// registered through a skid stage, plus sticky illegal-select and stall counter.
module alu_operand_fwd_mux
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned N_IN       = 4,
    parameter int unsigned SEL_WIDTH  = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_operand_fwd_mux_if.slave  bus
);

    logic [DATA_WIDTH-1:0] src [N_IN];
    logic [DATA_WIDTH-1:0] op_c;
    logic                  sel_bad_c;
    fwd_src_e              fwd_c;
    logic                  accept_c;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] mux_out;
    logic                  sel_err;
    logic [CNT_WIDTH-1:0]  stall_cnt;

    for (genvar k = 0; k < N_IN; k++) begin : g_src
        assign src[k] = bus.in_bus[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign fwd_c    = fwd_pick(bus.fwd_ex_en, bus.fwd_mem_en);
    assign accept_c = bus.in_valid && in_ready;

    // Out-of-range selects fall back to the last source.
    always_comb begin
        op_c      = src[N_IN-1];
        sel_bad_c = 1'b1;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (bus.sel == SEL_WIDTH'(k)) begin
                op_c      = src[k];
                sel_bad_c = 1'b0;
            end
        end
        case (fwd_c)
            FWD_EX:  op_c = bus.fwd_ex_data;
            FWD_MEM: op_c = bus.fwd_mem_data;
            default: begin end
        endcase
    end

    skid_buf2 #(
        .WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_data   (op_c),
        .in_valid  (bus.in_valid),
        .in_ready  (in_ready),
        .out_data  (mux_out),
        .out_valid (out_valid),
        .out_ready (bus.out_ready)
    );

    // Status: sel_err is sticky until reset, stall_cnt saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (accept_c && sel_bad_c && (fwd_c == FWD_NONE)) begin
                sel_err <= 1'b1;
            end
            if (out_valid && !bus.out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.mux_out   = mux_out;
    assign bus.sel_err   = sel_err;
    assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_alu_operand_fwd_mux.sv
// Scoreboard bench for alu_operand_fwd_mux (N_IN=3, SEL_WIDTH=2, CNT_WIDTH=4).
module tb_alu_operand_fwd_mux;

    localparam int unsigned DW = 32;
    localparam int unsigned NI = 3;
    localparam int unsigned SW = 2;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_operand_fwd_mux_if #(.DATA_WIDTH(DW), .N_IN(NI), .SEL_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

    alu_operand_fwd_mux #(.DATA_WIDTH(DW), .N_IN(NI), .SEL_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NI*DW-1:0] pack3(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                                              input logic [DW-1:0] s2);
        return {s2, s1, s0};
    endfunction

    // Monitor: every consumed output must match the oldest outstanding operand.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected: got 0x%0h expected no output", bus.mux_out);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(bus.mux_out), 64'(e));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [NI*DW-1:0] srcs, input logic [SW-1:0] s,
                        input logic exen, input logic [DW-1:0] exd,
                        input logic memen, input logic [DW-1:0] memd,
                        input logic [DW-1:0] exp);
        int  n;
        logic ok;
        bus.in_bus       = srcs;
        bus.sel          = s;
        bus.fwd_ex_en    = exen;
        bus.fwd_ex_data  = exd;
        bus.fwd_mem_en   = memen;
        bus.fwd_mem_data = memd;
        bus.in_valid     = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.in_ready === 1'b1) begin
                exp_q.push_back(exp);
                ok = 1'b1;
            end
        end
        check("send_accept", 64'(ok), 64'(1));
        cyc();
        bus.in_valid   = 1'b0;
        bus.fwd_ex_en  = 1'b0;
        bus.fwd_mem_en = 1'b0;
    endtask

    logic [NI*DW-1:0] p_basic;
    logic [NI*DW-1:0] p_123;
    logic [NI*DW-1:0] p_567;
    logic [NI*DW-1:0] p_a;

    initial begin
        p_basic = pack3(32'h11, 32'h22, 32'h33);
        p_123   = pack3(32'd1, 32'd2, 32'd3);
        p_567   = pack3(32'd5, 32'd6, 32'd7);
        p_a     = pack3(32'hA1, 32'hA2, 32'hA3);

        rst              = 1'b1;
        bus.in_bus       = '0;
        bus.sel          = '0;
        bus.in_valid     = 1'b0;
        bus.fwd_ex_en    = 1'b0;
        bus.fwd_ex_data  = '0;
        bus.fwd_mem_en   = 1'b0;
        bus.fwd_mem_data = '0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_mux_out",   64'(bus.mux_out),   64'(0));
        check("rst_in_ready",  64'(bus.in_ready),  64'(1));
        check("rst_sel_err",   64'(bus.sel_err),   64'(0));
        check("rst_stall_cnt", 64'(bus.stall_cnt), 64'(0));
        cyc();
        bus.out_ready = 1'b1;

        // Basic select and forward priority.
        send(p_basic, 2'd2, 1'b0, '0, 1'b0, '0, 32'h33);
        @(negedge clk);
        check("basic_sel_err", 64'(bus.sel_err), 64'(0));
        cyc();
        send(p_basic, 2'd1, 1'b1, 32'hCAFE, 1'b1, 32'hBEEF, 32'hCAFE);
        send(p_basic, 2'd1, 1'b0, 32'hCAFE, 1'b1, 32'hBEEF, 32'hBEEF);
        send(p_basic, 2'd0, 1'b0, '0, 1'b0, '0, 32'h11);
        repeat (2) cyc();

        // Back-pressure: A in output, B in skid, C held off.
        send(p_123, 2'd0, 1'b0, '0, 1'b0, '0, 32'd1);
        bus.out_ready = 1'b0;
        send(p_123, 2'd1, 1'b0, '0, 1'b0, '0, 32'd2);
        bus.in_bus   = p_123;
        bus.sel      = 2'd2;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
            check("bp_hold",     64'(bus.mux_out),  64'(1));
        end
        cyc();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        send(p_123, 2'd2, 1'b0, '0, 1'b0, '0, 32'd3);
        repeat (3) cyc();
        @(negedge clk);
        check("bp_stall_cnt", 64'(bus.stall_cnt), 64'(4));
        check("bp_drained",   64'(exp_q.size()),  64'(0));
        cyc();

        // Flush with a full skid and a pending input.
        bus.out_ready = 1'b0;
        send(p_a, 2'd0, 1'b0, '0, 1'b0, '0, 32'hA1);
        send(p_a, 2'd1, 1'b0, '0, 1'b0, '0, 32'hA2);
        @(negedge clk);
        check("fl_skid_full", 64'(bus.in_ready), 64'(0));
        cyc();
        bus.in_bus   = p_a;
        bus.sel      = 2'd2;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        exp_q.delete();
        cyc();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("fl_out_valid", 64'(bus.out_valid), 64'(0));
        check("fl_in_ready",  64'(bus.in_ready),  64'(1));
        cyc();
        // Flush while an accept would otherwise happen.
        bus.sel      = 2'd0;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        cyc();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("fl2_out_valid", 64'(bus.out_valid), 64'(0));
        repeat (4) cyc();

        // Illegal select: forwarded case is legal, unforwarded sets sticky flag.
        send(p_567, 2'd3, 1'b0, '0, 1'b1, 32'h5A5A, 32'h5A5A);
        @(negedge clk);
        check("ill_fwd_sel_err", 64'(bus.sel_err), 64'(0));
        cyc();
        send(p_567, 2'd3, 1'b0, '0, 1'b0, '0, 32'd7);
        @(negedge clk);
        check("ill_sel_err", 64'(bus.sel_err), 64'(1));
        cyc();
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        @(negedge clk);
        check("ill_sel_err_flush", 64'(bus.sel_err), 64'(1));
        cyc();

        // Saturation, then reset mid-stall.
        bus.out_ready = 1'b0;
        send(p_basic, 2'd0, 1'b0, '0, 1'b0, '0, 32'h11);
        repeat (20) cyc();
        @(negedge clk);
        check("sat_stall_cnt", 64'(bus.stall_cnt), 64'(15));
        check("sat_out_valid", 64'(bus.out_valid), 64'(1));
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mrst_stall_cnt", 64'(bus.stall_cnt), 64'(0));
        check("mrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mrst_mux_out",   64'(bus.mux_out),   64'(0));
        check("mrst_in_ready",  64'(bus.in_ready),  64'(1));
        check("mrst_sel_err",   64'(bus.sel_err),   64'(0));
        cyc();

        bus.out_ready = 1'b1;
        send(p_567, 2'd1, 1'b0, '0, 1'b0, '0, 32'd6);
        repeat (3) cyc();
        @(negedge clk);
        check("end_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, expected completion");
        $fatal(1);
    end

endmodule
